pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
- Sequencing controller for a serial overlapping pattern detector.
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first into a Mealy-style detector for a programmable PAT_W-bit pattern.
- Reports per-word match counts and keeps a saturating running total.
- Sits between a parallel data source and the serial detector datapath, and owns detector configuration and history.

Parameters:
- WORD_W, 8: bits per input word.
- PAT_W, 4: pattern length in bits; 2 <= PAT_W <= WORD_W.
- PAT_RESET, 4'b1001: pattern loaded at reset.
- CNT_W, 8: width of the running total counter.

Ports:
- clk, input, 1: system clock; all flops rise-edge.
- reset, input, 1: asynchronous, active-low reset.
- cfg_we, input, 1: load cfg_pattern (honoured in IDLE only).
- cfg_pattern, input, PAT_W: new pattern value.
- clear, input, 1: clear history and total_count (honoured in IDLE only).
- in_valid, input, 1: input word valid.
- in_data, input, WORD_W: input word.
- in_ready, output, 1: controller can accept a word.
- busy, output, 1: high in SHIFT or REPORT.
- ser_bit, output, 1: bit currently being scanned; 0 outside SHIFT.
- match, output, 1: combinational pulse; high in the SHIFT cycle whose bit completes the pattern.
- out_valid, output, 1: one-cycle pulse carrying the word result.
- out_count, output, $clog2(WORD_W+1): matches in the last word; held until the next REPORT.
- total_count, output, CNT_W: saturating count of all matches.
- pattern_q, output, PAT_W: active pattern.

Behaviour:
Reset (reset=0, asynchronous):
- State = IDLE; pattern_q = PAT_RESET.
- Shift register, bit index, history, history fill, word count, out_count and total_count all 0.
- out_valid = 0, match = 0, busy = 0, ser_bit = 0.
- in_ready = 1, since in_ready = (state==IDLE) combinationally.

FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge k: latch in_data, bit_idx = 0, word count = 0; next state SHIFT.
- SHIFT (cycles k+1 .. k+WORD_W):
  - ser_bit = shreg[WORD_W-1].
  - match = ({hist, ser_bit} == pattern_q) && (fill == PAT_W-1).
  - At each edge: hist <= {hist[PAT_W-3:0], ser_bit}; fill increments, saturating at PAT_W-1; shreg shifts left; bit_idx increments.
  - On match: word count +1; total_count +1, saturating at 2^CNT_W-1 with no wrap.
  - Leave SHIFT after bit_idx == WORD_W-1.
- REPORT (cycle k+WORD_W+1):
  - out_valid = 1 for exactly one cycle.
  - out_count = word count, including a match on the final bit; registered at entry.
  - Next state IDLE; in_ready is high again at cycle k+WORD_W+2.
- Throughput: one word per WORD_W+2 cycles.
- Result path has no backpressure: out_valid is a pulse, and the consumer must capture it.

Detector rules:
- Detection overlaps: the trailing bits of one match count toward the next.
- History persists across word boundaries, so a pattern spanning two consecutive words is counted in the word holding its last bit.
- No false matches from the zero-filled history after reset, clear or cfg_we; the fill counter gates matching.

Configuration and clear:
- cfg_we in IDLE: pattern_q <= cfg_pattern; history and fill cleared; total_count retained.
- cfg_we in SHIFT or REPORT: ignored entirely, with no deferred effect.
- clear in IDLE: history, fill and total_count cleared; out_count retained.
- clear in SHIFT or REPORT: ignored.

Simultaneous events in IDLE (same edge):
- cfg_we with in_valid: word accepted, and the new pattern applies to it from its first bit with empty history.
- clear with in_valid: word accepted with empty history; total_count starts from 0.
- cfg_we with clear: both take effect.

Other boundary conditions:
- in_valid outside IDLE: not accepted, since in_ready = 0; the source must hold the word.
- Reset mid-operation: immediate return to the reset state; out_valid is not generated for the aborted word.

Test Plan:
1. Reset, then send 8'b1001_0010 (pattern 1001):
   - match is high in SHIFT cycles 4 and 7 (bits 3 and 6, overlapping).
   - out_valid asserts at k+9 with out_count=2; total_count=2; in_ready is high at k+10.
2. Cross-word match: send 8'h04, then 8'h80:
   - Word 1 reports out_count=0.
   - Word 2 reports out_count=1, with match in its first SHIFT cycle.
   - Repeat with clear between the words: word 2 reports out_count=0.
3. Reconfiguration: cfg_we with 4'b1111 in IDLE, then send 8'hFF:
   - out_count=5 (bits 3–7); pattern_q=4'b1111.
   - Pulse cfg_we with 4'b0000 during SHIFT: pattern_q stays 4'b1111.
4. Saturation (CNT_W=3): pattern 1111, send 8'hFF twice:
   - out_count is 5, then 8, since history carries over.
   - total_count is 5, then saturates at 7 with no wrap.
5. Reset mid-SHIFT: drop reset at the 4th SHIFT cycle:
   - State goes to IDLE and in_ready=1 while reset is low.
   - No out_valid; pattern_q=4'b1001; total_count=0.
6. Back-to-back handshake: hold in_valid high with two words:
   - Second word is accepted exactly at cycle k+WORD_W+2.
   - in_ready is low throughout SHIFT and REPORT, and the first word's out_count is unaffected.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-to-serial sequencer for an overlapping pattern detector
//
// Accepts WORD_W-bit words on a valid/ready handshake, scans each word MSB-first
// through a Mealy detector for a programmable PAT_W-bit pattern, pulses the
// per-word match count on out_valid and keeps a saturating running total.
//
// Ports:
//   clk          rise-edge clock
//   reset        asynchronous active-low reset
//   cfg_we       load cfg_pattern (IDLE only), clears detector history
//   cfg_pattern  new pattern value
//   clear        clear history and total_count (IDLE only)
//   in_valid     input word valid
//   in_data      input word
//   in_ready     high in IDLE
//   busy         high in SHIFT or REPORT
//   ser_bit      bit under scan (0 outside SHIFT)
//   match        combinational, high in the SHIFT cycle completing the pattern
//   out_valid    one-cycle result pulse
//   out_count    matches in the last word, held until the next REPORT
//   total_count  saturating total of all matches
//   pattern_q    active pattern
module pattern_scan_ctrl #(
    parameter int               WORD_W    = 8,
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = 4'b1001,
    parameter int               CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [PAT_W-1:0]              cfg_pattern,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [WORD_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          busy,
    output logic                          ser_bit,
    output logic                          match,
    output logic                          out_valid,
    output logic [$clog2(WORD_W+1)-1:0]   out_count,
    output logic [CNT_W-1:0]              total_count,
    output logic [PAT_W-1:0]              pattern_q
);

    localparam int OUT_W  = $clog2(WORD_W + 1);
    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    logic [1:0]        state;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [OUT_W-1:0]  word_cnt;
    logic [PAT_W-1:0]  window;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == REPORT);
    assign ser_bit   = (state == SHIFT) & shreg[WORD_W-1];

    // The previous PAT_W-1 bits plus the current one; the fill counter keeps the
    // zero-initialised history from producing matches before it holds real bits.
    assign window = {hist, ser_bit};
    assign match  = (state == SHIFT) && (window == pattern_q) && (fill == FILL_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pattern_q   <= PAT_RESET;
            shreg       <= '0;
            bit_idx     <= '0;
            hist        <= '0;
            fill        <= '0;
            word_cnt    <= '0;
            out_count   <= '0;
            total_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pattern_q <= cfg_pattern;
                        hist      <= '0;
                        fill      <= '0;
                    end
                    if (clear) begin
                        hist        <= '0;
                        fill        <= '0;
                        total_count <= '0;
                    end
                    if (in_valid) begin
                        shreg    <= in_data;
                        bit_idx  <= '0;
                        word_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    hist    <= window[PAT_W-2:0];
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    bit_idx <= bit_idx + 1'b1;
                    if (fill != FILL_MAX) begin
                        fill <= fill + 1'b1;
                    end
                    if (match) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (total_count != {CNT_W{1'b1}}) begin
                            total_count <= total_count + 1'b1;
                        end
                    end
                    if (bit_idx == LAST_IDX) begin
                        // Fold in a match on the final bit so REPORT sees the full count.
                        out_count <= word_cnt + OUT_W'(match);
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready, busy, ser_bit, match, out_valid;
    logic [3:0] out_count;
    logic [7:0] total_count;
    logic [3:0] pattern_q;

    logic       in_ready_s, busy_s, ser_bit_s, match_s, out_valid_s;
    logic [3:0] out_count_s;
    logic [2:0] total_count_s;
    logic [3:0] pattern_q_s;

    pattern_scan_ctrl dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .ser_bit(ser_bit), .match(match),
        .out_valid(out_valid), .out_count(out_count), .total_count(total_count),
        .pattern_q(pattern_q)
    );

    pattern_scan_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .busy(busy_s), .ser_bit(ser_bit_s), .match(match_s),
        .out_valid(out_valid_s), .out_count(out_count_s), .total_count(total_count_s),
        .pattern_q(pattern_q_s)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the scanned bit stream since the last history flush,
    // the active pattern, and the number of matches since the last clear.
    logic       mq[$];
    logic [3:0] mpat;
    int         mtotal;
    int         mlast;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpat   = 4'b1001;
        mtotal = 0;
        mlast  = 0;
    endtask

    task automatic model_bit(input logic b, output logic hit);
        mq.push_back(b);
        hit = 1'b0;
        if (mq.size() >= PAT_W) begin
            hit = 1'b1;
            for (int j = 0; j < PAT_W; j++)
                if (mq[mq.size() - PAT_W + j] !== mpat[PAT_W-1-j]) hit = 1'b0;
        end
        while (mq.size() > PAT_W) void'(mq.pop_front());
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_oval"}, 32'(out_valid), 32'd0);
        chk({tag, "_match"}, 32'(match), 32'd0);
        chk({tag, "_ser"}, 32'(ser_bit), 32'd0);
        chk({tag, "_pat"}, 32'(pattern_q), 32'(mpat));
        chk({tag, "_ocnt"}, 32'(out_count), 32'(mlast));
        chk({tag, "_tot"}, 32'(total_count), 32'(sat(mtotal, 255)));
        chk({tag, "_tot_s"}, 32'(total_count_s), 32'(sat(mtotal, 7)));
    endtask

    task automatic clear_idle();
        clear = 1'b1;
        @(posedge clk); @(negedge clk);
        clear = 1'b0;
        mq.delete();
        mtotal = 0;
        check_idle("clr");
    endtask

    task automatic cfg_idle(input logic [3:0] p);
        cfg_we = 1'b1; cfg_pattern = p;
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
        mpat = p;
        mq.delete();
        check_idle("cfg");
    endtask

    // Called at a falling edge in IDLE. noise: 0 none, 1 random cfg/clear
    // pulses during SHIFT/REPORT, 2 cfg_we with 4'b0000 during SHIFT/REPORT.
    // keep leaves in_valid high with next_d for a back-to-back word.
    task automatic send_word(input logic [7:0] d, input logic cfg, input logic [3:0] cp,
                             input logic clr, input int noise, input bit keep,
                             input logic [7:0] next_d, input int abort_at);
        int   cnt;
        logic hit;
        chk("pre_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; cfg_we = cfg; cfg_pattern = cp; clear = clr;
        if (clr) begin mq.delete(); mtotal = 0; end
        if (cfg) begin mpat = cp; mq.delete(); end
        @(posedge clk); @(negedge clk);
        in_valid = keep; in_data = next_d; cfg_we = 1'b0; clear = 1'b0;
        cnt = 0;
        for (int i = 0; i < WORD_W; i++) begin
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                model_reset();
                chk("rst_ready", 32'(in_ready), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_oval", 32'(out_valid), 32'd0);
                chk("rst_pat", 32'(pattern_q), 32'h9);
                chk("rst_tot", 32'(total_count), 32'd0);
                chk("rst_ser", 32'(ser_bit), 32'd0);
                chk("rst_match", 32'(match), 32'd0);
                repeat (2) begin
                    @(posedge clk); @(negedge clk);
                    chk("rst_hold_oval", 32'(out_valid), 32'd0);
                    chk("rst_hold_ready", 32'(in_ready), 32'd1);
                end
                in_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                chk("post_rst_oval", 32'(out_valid), 32'd0);
                return;
            end
            model_bit(d[7-i], hit);
            if (hit) begin cnt++; mtotal++; end
            chk($sformatf("ser_b%0d", i), 32'(ser_bit), 32'(d[7-i]));
            chk($sformatf("match_b%0d", i), 32'(match), 32'(hit));
            chk("shift_busy", 32'(busy), 32'd1);
            chk("shift_ready", 32'(in_ready), 32'd0);
            chk("shift_oval", 32'(out_valid), 32'd0);
            if (noise == 1) begin
                cfg_we = 1'($urandom); cfg_pattern = 4'($urandom); clear = 1'($urandom);
            end else if (noise == 2) begin
                cfg_we = 1'b1; cfg_pattern = 4'b0000;
            end
            @(posedge clk); @(negedge clk);
        end
        mlast = cnt;
        chk("rep_oval", 32'(out_valid), 32'd1);
        chk("rep_ocnt", 32'(out_count), 32'(cnt));
        chk("rep_busy", 32'(busy), 32'd1);
        chk("rep_ready", 32'(in_ready), 32'd0);
        chk("rep_tot", 32'(total_count), 32'(sat(mtotal, 255)));
        chk("rep_tot_s", 32'(total_count_s), 32'(sat(mtotal, 7)));
        chk("rep_pat", 32'(pattern_q), 32'(mpat));
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0; clear = 1'b0;
        if (!keep) in_valid = 1'b0;
        chk("done_ready", 32'(in_ready), 32'd1);
        chk("done_oval", 32'(out_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ocnt", 32'(out_count), 32'(mlast));
    endtask

    initial begin
        logic [7:0] cur, nxt;
        bit         kp, prev_keep;
        reset = 1'b0; cfg_we = 1'b0; cfg_pattern = 4'h0; clear = 1'b0;
        in_valid = 1'b0; in_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle("idle0");

        // Overlapping matches inside one word.
        send_word(8'b1001_0010, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);
        chk("t1_cnt_const", 32'(out_count), 32'd2);

        // Match spanning a word boundary, then the same with clear between.
        send_word(8'h04, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);
        send_word(8'h80, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);
        chk("t2_cross_const", 32'(out_count), 32'd1);
        send_word(8'h04, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);
        clear_idle();
        send_word(8'h80, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);

        // Reconfiguration, with an ignored cfg_we during SHIFT.
        cfg_idle(4'b1111);
        send_word(8'hFF, 1'b0, 4'h0, 1'b0, 2, 1'b0, 8'h00, -1);
        check_idle("t3");

        // Saturation of the 3-bit total.
        clear_idle();
        send_word(8'hFF, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);
        send_word(8'hFF, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);
        chk("t4_sat_const", 32'(total_count_s), 32'd7);

        // Reset in the fourth SHIFT cycle.
        send_word(8'h5A, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, 3);
        check_idle("t5");

        // Back-to-back words with in_valid held.
        send_word(8'h99, 1'b0, 4'h0, 1'b0, 0, 1'b1, 8'h93, -1);
        send_word(8'h93, 1'b0, 4'h0, 1'b0, 0, 1'b0, 8'h00, -1);

        // Randomised traffic, configuration and clears.
        prev_keep = 1'b0;
        nxt = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            cur = nxt;
            nxt = 8'($urandom);
            kp  = ($urandom_range(0, 2) == 0);
            if (!prev_keep && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_idle("gap");
            end
            send_word(cur, ($urandom_range(0, 5) == 0), 4'($urandom),
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 1), kp, nxt, -1);
            prev_keep = kp;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
